pifo_pop_collector: RTL and testbench

- Downstream consumer of the multi-tree SRAM PIFO top. Each cycle, every lane may report a level-0 pop result: `i_is_level0_pop[l]`, `i_tree_id[l]` and `i_pop_data[l]`.
- The block merges up to LEVEL results per cycle into one ring buffer, in lane order. It presents them as a single valid/ready stream toward the egress scheduler.
- It also keeps per-tree outstanding-pop counters, so pop requests can be matched against returned results, and it raises sticky error flags.

---
 rtl/pifo_pop_collector.sv | 156 +++++++++++++++
 tb/tb_pifo_pop_collector.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_pop_collector.sv
// rtl/pifo_pop_collector.sv - merges per-lane PIFO pop results into one FWFT stream with outstanding-pop tracking
//
// Collects up to LEVEL level-0 pop results per cycle into a flop-based ring
// buffer, in ascending lane order, and presents the head entry as a
// first-word-fall-through valid/ready stream. Also tracks outstanding pops
// per tree and raises sticky overflow / unexpected-result flags.
//
// Ports:
//   i_clk, i_arst_n            clock, asynchronous active-low reset
//   i_pop_req[l]               lane l issued a pop request for tree i_pop_req_tree_id[l]
//   i_is_level0_pop[l]         lane l delivers a result (i_tree_id[l], i_pop_data[l])
//   o_valid/i_ready            head entry handshake
//   o_tree_id/o_data           head entry contents
//   o_empty_pop                head data is all-ones (tree was empty)
//   o_count                    buffer occupancy
//   o_outstanding[t]           outstanding pops for tree t
//   o_overflow/o_unexpected    sticky error flags, cleared by i_clr_err
module pifo_pop_collector #(
  parameter int PTW      = 16,
  parameter int MTW      = 0,
  parameter int LEVEL    = 4,
  parameter int TREE_NUM = 4,
  parameter int DEPTH    = 16,
  parameter int CNTW     = 8,
  localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
  localparam int DW            = MTW + PTW,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic [LEVEL-1:0]         i_pop_req,
  input  logic [TREE_NUM_BITS-1:0] i_pop_req_tree_id [0:LEVEL-1],
  input  logic [LEVEL-1:0]         i_is_level0_pop,
  input  logic [TREE_NUM_BITS-1:0] i_tree_id [0:LEVEL-1],
  input  logic [DW-1:0]            i_pop_data [0:LEVEL-1],
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [TREE_NUM_BITS-1:0] o_tree_id,
  output logic [DW-1:0]            o_data,
  output logic                     o_empty_pop,
  output logic [AW:0]              o_count,
  output logic [CNTW-1:0]          o_outstanding [0:TREE_NUM-1],
  output logic                     o_overflow,
  output logic                     o_unexpected,
  input  logic                     i_clr_err
);

  localparam int CMAX = (1 << CNTW) - 1;

  logic [TREE_NUM_BITS-1:0] r_mem_tid  [0:DEPTH-1];
  logic [DW-1:0]            r_mem_data [0:DEPTH-1];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [AW:0]              r_count;
  logic [CNTW-1:0]          r_outstanding [0:TREE_NUM-1];
  logic                     r_overflow;
  logic                     r_unexpected;

  logic [AW:0]              w_free;
  logic [AW:0]              w_wr_cnt;
  logic [LEVEL-1:0]         w_wen;
  logic [AW-1:0]            w_waddr [0:LEVEL-1];
  logic                     w_drop;
  logic                     w_fire;
  logic signed [CNTW+1:0]   w_sum [0:TREE_NUM-1];
  logic [CNTW-1:0]          w_out_nxt [0:TREE_NUM-1];
  logic                     w_unexp;

  // Lane packing: each active lane takes the next slot after the lanes below
  // it. Space is judged from the registered count only, so a same-cycle pop
  // never makes room for a write.
  always_comb begin
    w_free   = (AW+1)'(DEPTH) - r_count;
    w_wr_cnt = '0;
    w_drop   = 1'b0;
    w_wen    = '0;
    for (int l = 0; l < LEVEL; l++) begin
      w_waddr[l] = r_wr_ptr + w_wr_cnt[AW-1:0];
      if (i_is_level0_pop[l]) begin
        if (w_wr_cnt < w_free) begin
          w_wen[l] = 1'b1;
          w_wr_cnt = w_wr_cnt + (AW+1)'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  // Outstanding counters: dropped results still decrement, since the pop
  // request they answer has completed either way.
  always_comb begin
    w_unexp = 1'b0;
    for (int t = 0; t < TREE_NUM; t++) begin
      w_sum[t] = signed'({2'b00, r_outstanding[t]});
      for (int l = 0; l < LEVEL; l++) begin
        if (i_pop_req[l] && (i_pop_req_tree_id[l] == TREE_NUM_BITS'(t)))
          w_sum[t] = w_sum[t] + (CNTW+2)'(1);
        if (i_is_level0_pop[l] && (i_tree_id[l] == TREE_NUM_BITS'(t)))
          w_sum[t] = w_sum[t] - (CNTW+2)'(1);
      end
      if (w_sum[t] < 0) begin
        w_out_nxt[t] = '0;
        w_unexp      = 1'b1;
      end else if (w_sum[t] > CMAX) begin
        w_out_nxt[t] = '1;
      end else begin
        w_out_nxt[t] = w_sum[t][CNTW-1:0];
      end
    end
  end

  assign w_fire = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_unexpected <= 1'b0;
      for (int d = 0; d < DEPTH; d++) begin
        r_mem_tid[d]  <= '0;
        r_mem_data[d] <= '0;
      end
      for (int t = 0; t < TREE_NUM; t++) r_outstanding[t] <= '0;
    end else begin
      for (int l = 0; l < LEVEL; l++) begin
        if (w_wen[l]) begin
          r_mem_tid[w_waddr[l]]  <= i_tree_id[l];
          r_mem_data[w_waddr[l]] <= i_pop_data[l];
        end
      end
      r_wr_ptr <= r_wr_ptr + w_wr_cnt[AW-1:0];
      if (w_fire) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + w_wr_cnt - (AW+1)'(w_fire);
      for (int t = 0; t < TREE_NUM; t++) r_outstanding[t] <= w_out_nxt[t];
      // A new error in the clearing cycle wins over the clear.
      r_overflow   <= w_drop  | (r_overflow   & ~i_clr_err);
      r_unexpected <= w_unexp | (r_unexpected & ~i_clr_err);
    end
  end

  assign o_valid      = (r_count != '0);
  assign o_tree_id    = r_mem_tid[r_rd_ptr];
  assign o_data       = r_mem_data[r_rd_ptr];
  assign o_empty_pop  = &o_data;
  assign o_count      = r_count;
  assign o_overflow   = r_overflow;
  assign o_unexpected = r_unexpected;

  always_comb begin
    for (int t = 0; t < TREE_NUM; t++) o_outstanding[t] = r_outstanding[t];
  end

endmodule

// File: tb/tb_pifo_pop_collector.sv
// tb/tb_pifo_pop_collector.sv - self-checking bench for pifo_pop_collector
module tb_pifo_pop_collector;

  logic        i_clk = 1'b0;
  logic        i_arst_n;
  logic [3:0]  i_pop_req;
  logic [1:0]  i_pop_req_tree_id [0:3];
  logic [3:0]  i_is_level0_pop;
  logic [1:0]  i_tree_id [0:3];
  logic [15:0] i_pop_data [0:3];
  logic        o_valid;
  logic        i_ready;
  logic [1:0]  o_tree_id;
  logic [15:0] o_data;
  logic        o_empty_pop;
  logic [4:0]  o_count;
  logic [7:0]  o_outstanding [0:3];
  logic        o_overflow;
  logic        o_unexpected;
  logic        i_clr_err;

  pifo_pop_collector dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n),
    .i_pop_req(i_pop_req), .i_pop_req_tree_id(i_pop_req_tree_id),
    .i_is_level0_pop(i_is_level0_pop), .i_tree_id(i_tree_id), .i_pop_data(i_pop_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_tree_id(o_tree_id), .o_data(o_data),
    .o_empty_pop(o_empty_pop), .o_count(o_count), .o_outstanding(o_outstanding),
    .o_overflow(o_overflow), .o_unexpected(o_unexpected), .i_clr_err(i_clr_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [1:0]  tid;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  rtid;
    logic [3:0]  pop;
    logic [7:0]  tid;
    logic [63:0] data;
    logic        rdy;
    logic        clr;
    int          e_count;
    logic        e_valid;
    int          c_tree;
    int          e_out;
    logic        e_unx;
    logic        e_empty;
  } row_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_count;
  int   m_out [4];
  logic m_ovf, m_unx;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pk(input int b);
    return {16'(b + 3), 16'(b + 2), 16'(b + 1), 16'(b)};
  endfunction

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_unx   = 1'b0;
    for (int t = 0; t < 4; t++) m_out[t] = 0;
  endtask

  task automatic idle_inputs();
    i_pop_req = '0; i_is_level0_pop = '0; i_ready = 1'b0; i_clr_err = 1'b0;
    for (int l = 0; l < 4; l++) begin
      i_pop_req_tree_id[l] = '0; i_tree_id[l] = '0; i_pop_data[l] = '0;
    end
  endtask

  // Head entry is checked against the scoreboard just before each firing edge.
  always @(negedge i_clk) begin
    if (i_arst_n && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_output act_tid=%0d act_data=%h exp=none", o_tree_id, o_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_tid", o_tree_id, e.tid);
        chk("out_data", o_data, e.data);
        chk("out_empty", o_empty_pop, (e.data == 16'hFFFF) ? 1 : 0);
      end
    end
  end

  // One clock of stimulus; the model predicts capture, drops and counters.
  task automatic step(input logic [3:0] req, input logic [7:0] rtid, input logic [3:0] pop,
                      input logic [7:0] tid, input logic [63:0] data, input logic rdy,
                      input logic clr);
    int   free, wr, fire, nx;
    int   inc [4];
    int   dec [4];
    logic e_ovf, e_unx;
    i_pop_req = req; i_is_level0_pop = pop; i_ready = rdy; i_clr_err = clr;
    for (int l = 0; l < 4; l++) begin
      i_pop_req_tree_id[l] = rtid[2*l +: 2];
      i_tree_id[l]         = tid[2*l +: 2];
      i_pop_data[l]        = data[16*l +: 16];
    end
    free = 16 - m_count; wr = 0; e_ovf = 1'b0; e_unx = 1'b0;
    for (int t = 0; t < 4; t++) begin inc[t] = 0; dec[t] = 0; end
    for (int l = 0; l < 4; l++) begin
      if (req[l]) inc[rtid[2*l +: 2]]++;
      if (pop[l]) begin
        dec[tid[2*l +: 2]]++;
        if (wr < free) begin
          sb.push_back(exp_t'{tid[2*l +: 2], data[16*l +: 16]});
          wr++;
        end else e_ovf = 1'b1;
      end
    end
    fire = (m_count != 0 && rdy) ? 1 : 0;
    for (int t = 0; t < 4; t++) begin
      nx = m_out[t] + inc[t] - dec[t];
      if (nx < 0) begin nx = 0; e_unx = 1'b1; end
      else if (nx > 255) nx = 255;
      m_out[t] = nx;
    end
    m_count = m_count + wr - fire;
    m_ovf = e_ovf | (m_ovf & ~clr);
    m_unx = e_unx | (m_unx & ~clr);
    @(posedge i_clk); #1;
    chk("count", o_count, m_count);
    chk("overflow", o_overflow, m_ovf);
    chk("unexpected", o_unexpected, m_unx);
    for (int t = 0; t < 4; t++) chk($sformatf("outstanding%0d", t), o_outstanding[t], m_out[t]);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      step(4'h0, 8'h00, 4'h0, 8'h00, 64'h0, 1'b1, 1'b0);
      n++;
    end
    chk({nm, "_drained"}, sb.size(), 0);
    chk({nm, "_valid_low"}, o_valid, 0);
  endtask

  row_t rows [10];

  initial begin
    int prev;
    // basic capture/drain, multi-lane ordering, unexpected + empty pop
    rows[0] = '{4'b0001, 8'h02, 4'b0000, 8'h00, 64'h0, 1'b1, 1'b0, 0, 1'b0, 2, 1, 1'b0, 1'b0};
    rows[1] = '{4'b0000, 8'h00, 4'b0001, 8'h02, 64'h5, 1'b1, 1'b0, 1, 1'b1, 2, 0, 1'b0, 1'b0};
    rows[2] = '{4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b1, 1'b0, 0, 1'b0, 2, 0, 1'b0, 1'b0};
    rows[3] = '{4'b1011, 8'h55, 4'b0000, 8'h00, 64'h0, 1'b1, 1'b0, 0, 1'b0, 1, 3, 1'b0, 1'b0};
    rows[4] = '{4'b0000, 8'h00, 4'b1011, 8'h55, 64'h00A3_0000_00A1_00A0, 1'b1, 1'b0, 3, 1'b1, 1, 0, 1'b0, 1'b0};
    rows[5] = '{4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b1, 1'b0, 2, 1'b1, 1, 0, 1'b0, 1'b0};
    rows[6] = '{4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b1, 1'b0, 1, 1'b1, 1, 0, 1'b0, 1'b0};
    rows[7] = '{4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b1, 1'b0, 0, 1'b0, 1, 0, 1'b0, 1'b0};
    rows[8] = '{4'b0000, 8'h00, 4'b0010, 8'h0C, 64'h0000_0000_FFFF_0000, 1'b0, 1'b0, 1, 1'b1, 3, 0, 1'b1, 1'b1};
    rows[9] = '{4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b1, 1'b1, 0, 1'b0, 3, 0, 1'b0, 1'b0};

    idle_inputs();
    model_reset();
    i_arst_n = 1'b0;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_tid", o_tree_id, 0);
    chk("rst_data", o_data, 0);
    chk("rst_empty", o_empty_pop, 0);
    chk("rst_count", o_count, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_unx", o_unexpected, 0);
    for (int t = 0; t < 4; t++) chk("rst_outstanding", o_outstanding[t], 0);
    @(negedge i_clk); i_arst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int r = 0; r < 10; r++) begin
      step(rows[r].req, rows[r].rtid, rows[r].pop, rows[r].tid, rows[r].data, rows[r].rdy, rows[r].clr);
      chk($sformatf("row%0d_count", r), o_count, rows[r].e_count);
      chk($sformatf("row%0d_valid", r), o_valid, rows[r].e_valid);
      chk($sformatf("row%0d_out", r), o_outstanding[rows[r].c_tree], rows[r].e_out);
      chk($sformatf("row%0d_unx", r), o_unexpected, rows[r].e_unx);
      chk($sformatf("row%0d_empty", r), o_empty_pop, rows[r].e_empty);
    end
    chk("table_sb_empty", sb.size(), 0);

    // overflow: fill to 14, then four more with only two slots left
    for (int i = 0; i < 3; i++)
      step(4'b1111, 8'h1B, 4'b1111, 8'h1B, pk(16'h100 + 4*i), 1'b0, 1'b0);
    step(4'b0011, 8'h1B, 4'b0011, 8'h1B, pk(16'h10C), 1'b0, 1'b0);
    chk("ovf_fill14", o_count, 14);
    step(4'b1111, 8'h1B, 4'b1111, 8'h1B, pk(16'h0C0), 1'b0, 1'b0);
    chk("ovf_count16", o_count, 16);
    chk("ovf_flag", o_overflow, 1);
    step(4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b0, 1'b1);
    chk("ovf_cleared", o_overflow, 0);
    chk("ovf_hold16", o_count, 16);
    drain("ovf");

    // wrap-around: 40 results, ready toggling, write and fire coincide
    for (int c = 0; c < 80; c++) begin
      int l;
      l = (c / 2) % 4;
      prev = o_count;
      if (c % 2 == 0)
        step(4'(1 << l), {4{2'(l)}}, 4'(1 << l), {4{2'(l)}},
             64'(16'h200 + c / 2) << (16 * l), 1'b1, 1'b0);
      else
        step(4'h0, 8'h00, 4'h0, 8'h00, 64'h0, 1'b0, 1'b0);
      chk("wrap_max", (o_count <= 16) ? 1 : 0, 1);
      if (c % 2 == 0 && prev != 0) chk("wrap_hold", o_count, prev);
    end
    drain("wrap");

    // asynchronous reset mid-stream
    step(4'b0111, 8'h15, 4'b0000, 8'h00, 64'h0, 1'b0, 1'b0);
    step(4'b1111, 8'h00, 4'b1111, 8'h00, pk(16'h300), 1'b0, 1'b0);
    step(4'b0000, 8'h00, 4'b0001, 8'h02, 64'h33, 1'b0, 1'b0);
    chk("pre_rst_count", o_count, 5);
    chk("pre_rst_out1", o_outstanding[1], 3);
    chk("pre_rst_unx", o_unexpected, 1);
    idle_inputs();
    i_arst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_count", o_count, 0);
    chk("arst_ovf", o_overflow, 0);
    chk("arst_unx", o_unexpected, 0);
    for (int t = 0; t < 4; t++) chk("arst_outstanding", o_outstanding[t], 0);
    model_reset();
    @(negedge i_clk); i_arst_n = 1'b1;
    @(posedge i_clk); #1;
    step(4'b0001, 8'h01, 4'b0000, 8'h00, 64'h0, 1'b1, 1'b0);
    step(4'b0000, 8'h00, 4'b0001, 8'h01, 64'h77, 1'b1, 1'b0);
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_data", o_data, 16'h77);
    chk("post_rst_tid", o_tree_id, 1);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
